// File: rtl/apb_sb_pkg.sv
// Shared definitions for the APB south bridge: FSM state encoding, error-log
// codes, the default error read data and the wait-counter width helper.
package apb_sb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] ERR_CODE_NONE     = 2'b00;
  localparam logic [1:0] ERR_CODE_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_CODE_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_CODE_SLVERR   = 2'b11;

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  // Wait counter needs to hold TIMEOUT; keep at least one bit when disabled.
  function automatic int cnt_width(input int unsigned timeout);
    if (timeout == 32'd0) begin
      return 1;
    end else begin
      return $clog2(timeout + 32'd1);
    end
  endfunction

endpackage

// File: rtl/apb_sb_dec.sv
// Slot decoder: turns the PADDR slot field into an index, a one-hot select
// and a flag telling whether the slot exists and is populated.
module apb_sb_dec #(
  parameter int unsigned NSLV    = 16,
  parameter int unsigned DEC_W   = 4,
  parameter logic [31:0] SLV_MAP = 32'h0000_03FF
) (
  input  logic [DEC_W-1:0] field,
  output logic [DEC_W-1:0] idx,
  output logic [NSLV-1:0]  onehot,
  output logic             mapped
);

  logic [31:0] idx_ext_s;

  assign idx_ext_s = 32'(field);

  // Decode the slot field; indices past NSLV never select and are unmapped.
  always_comb begin
    idx    = field;
    onehot = {NSLV{1'b0}};
    for (int i = 0; i < NSLV; i++) begin
      onehot[i] = (idx_ext_s == 32'(i));
    end
    mapped = (idx_ext_s < 32'(NSLV)) && SLV_MAP[idx_ext_s[4:0]];
  end

endmodule

// File: rtl/apb_sb_gen.sv
// APB south bridge: one APB master fanned out to NSLV slave slots through a
// registered SETUP/ACCESS re-timing FSM, with error responses for unmapped
// slots, a per-transfer wait timeout and masked IRQ aggregation.
// Optional build macro APB_SB_ERR_LOG_EN adds a first-error capture log
// (ERR_ADDR/ERR_CODE/ERR_VALID, cleared by ERR_CLR).
module apb_sb_gen
  import apb_sb_pkg::*;
#(
  parameter int unsigned NSLV          = 16,
  parameter int unsigned DEC_LSB       = 16,
  parameter int unsigned DEC_W         = 4,
  parameter logic [31:0] SLV_MAP       = 32'h0000_03FF,
  parameter int unsigned TIMEOUT       = 255,
  parameter logic [31:0] DEFAULT_RDATA = DEAD_BEEF
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [31:0]         PADDR,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [31:0]         PWDATA,
  output logic [31:0]         PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  output logic [NSLV-1:0]     PIRQ,
  output logic [NSLV-1:0]     PSEL_S,
  output logic                PENABLE_S,
  output logic [31:0]         PADDR_S,
  output logic                PWRITE_S,
  output logic [31:0]         PWDATA_S,
  input  logic [NSLV*32-1:0]  PRDATA_S,
  input  logic [NSLV-1:0]     PREADY_S,
  input  logic [NSLV-1:0]     PSLVERR_S,
`ifdef APB_SB_ERR_LOG_EN
  output logic [31:0]         ERR_ADDR,
  output logic [1:0]          ERR_CODE,
  output logic                ERR_VALID,
  input  logic                ERR_CLR,
`endif
  input  logic [NSLV-1:0]     PIRQ_S
);

  localparam int            CW      = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_TO  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic          TO_EN   = (TIMEOUT != 32'd0);

  state_e            state_r, state_nxt_s;
  logic [DEC_W-1:0]  idx_r, idx_nxt_s;
  logic [CW-1:0]     cnt_r, cnt_nxt_s;
  logic [NSLV-1:0]   psel_s_r, psel_nxt_s;
  logic              penable_s_r, penable_nxt_s;
  logic [31:0]       paddr_s_r, paddr_nxt_s;
  logic              pwrite_s_r, pwrite_nxt_s;
  logic [31:0]       pwdata_s_r, pwdata_nxt_s;
  logic [31:0]       prdata_r, prdata_nxt_s;
  logic              pready_r, pready_nxt_s;
  logic              pslverr_r, pslverr_nxt_s;

  logic [DEC_W-1:0]  dec_idx_s;
  logic [NSLV-1:0]   dec_onehot_s;
  logic              dec_mapped_s;
  logic              accept_s;
  logic              to_hit_s;
  logic [31:0]       sl_rdata_s;
  logic              sl_ready_s;
  logic              sl_err_s;

  apb_sb_dec #(
    .NSLV    (NSLV),
    .DEC_W   (DEC_W),
    .SLV_MAP (SLV_MAP)
  ) u_dec (
    .field  (PADDR[DEC_LSB +: DEC_W]),
    .idx    (dec_idx_s),
    .onehot (dec_onehot_s),
    .mapped (dec_mapped_s)
  );

  assign accept_s = PSEL & ~PENABLE;
  assign to_hit_s = TO_EN && (cnt_r == CNT_TO);

  // Select the addressed slave's response using the captured slot index.
  always_comb begin
    sl_rdata_s = 32'h0000_0000;
    sl_ready_s = 1'b0;
    sl_err_s   = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      sl_rdata_s = sl_rdata_s | (PRDATA_S[32*i +: 32] & {32{(32'(idx_r) == 32'(i))}});
      sl_ready_s = sl_ready_s | (PREADY_S[i] & (32'(idx_r) == 32'(i)));
      sl_err_s   = sl_err_s | (PSLVERR_S[i] & (32'(idx_r) == 32'(i)));
    end
  end

  // FSM state register; reset aborts any transfer in flight.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = dec_mapped_s ? ST_SETUP : ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP:  state_nxt_s = ST_ACCESS;
      ST_ACCESS: begin
        if (sl_ready_s || to_hit_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_DONE:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values for every registered output and datapath reg.
  always_comb begin
    idx_nxt_s     = idx_r;
    cnt_nxt_s     = cnt_r;
    psel_nxt_s    = psel_s_r;
    penable_nxt_s = penable_s_r;
    paddr_nxt_s   = paddr_s_r;
    pwrite_nxt_s  = pwrite_s_r;
    pwdata_nxt_s  = pwdata_s_r;
    prdata_nxt_s  = prdata_r;
    pready_nxt_s  = 1'b0;
    pslverr_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          idx_nxt_s    = dec_idx_s;
          paddr_nxt_s  = PADDR;
          pwrite_nxt_s = PWRITE;
          pwdata_nxt_s = PWDATA;
          if (dec_mapped_s) begin
            psel_nxt_s = dec_onehot_s;
          end else begin
            prdata_nxt_s  = DEFAULT_RDATA;
            pready_nxt_s  = 1'b1;
            pslverr_nxt_s = 1'b1;
          end
        end else begin
          psel_nxt_s    = {NSLV{1'b0}};
          penable_nxt_s = 1'b0;
        end
      end
      ST_SETUP: begin
        cnt_nxt_s     = {CW{1'b0}};
        penable_nxt_s = 1'b1;
      end
      ST_ACCESS: begin
        if (sl_ready_s) begin
          psel_nxt_s    = {NSLV{1'b0}};
          penable_nxt_s = 1'b0;
          prdata_nxt_s  = sl_rdata_s;
          pready_nxt_s  = 1'b1;
          pslverr_nxt_s = sl_err_s;
        end else begin
          cnt_nxt_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CW'(1));
          if (to_hit_s) begin
            psel_nxt_s    = {NSLV{1'b0}};
            penable_nxt_s = 1'b0;
            prdata_nxt_s  = DEFAULT_RDATA;
            pready_nxt_s  = 1'b1;
            pslverr_nxt_s = 1'b1;
          end else begin
            penable_nxt_s = 1'b1;
          end
        end
      end
      ST_DONE: begin
        psel_nxt_s    = {NSLV{1'b0}};
        penable_nxt_s = 1'b0;
      end
      default: begin
        psel_nxt_s    = {NSLV{1'b0}};
        penable_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      idx_r       <= {DEC_W{1'b0}};
      cnt_r       <= {CW{1'b0}};
      psel_s_r    <= {NSLV{1'b0}};
      penable_s_r <= 1'b0;
      paddr_s_r   <= 32'h0000_0000;
      pwrite_s_r  <= 1'b0;
      pwdata_s_r  <= 32'h0000_0000;
      prdata_r    <= 32'h0000_0000;
      pready_r    <= 1'b0;
      pslverr_r   <= 1'b0;
    end else begin
      idx_r       <= idx_nxt_s;
      cnt_r       <= cnt_nxt_s;
      psel_s_r    <= psel_nxt_s;
      penable_s_r <= penable_nxt_s;
      paddr_s_r   <= paddr_nxt_s;
      pwrite_s_r  <= pwrite_nxt_s;
      pwdata_s_r  <= pwdata_nxt_s;
      prdata_r    <= prdata_nxt_s;
      pready_r    <= pready_nxt_s;
      pslverr_r   <= pslverr_nxt_s;
    end
  end

  assign PRDATA    = prdata_r;
  assign PREADY    = pready_r;
  assign PSLVERR   = pslverr_r;
  assign PSEL_S    = psel_s_r;
  assign PENABLE_S = penable_s_r;
  assign PADDR_S   = paddr_s_r;
  assign PWRITE_S  = pwrite_s_r;
  assign PWDATA_S  = pwdata_s_r;
  assign PIRQ      = PIRQ_S & SLV_MAP[NSLV-1:0];

`ifdef APB_SB_ERR_LOG_EN
  logic        log_now_s;
  logic [1:0]  err_code_s;
  logic [31:0] err_addr_r;
  logic [1:0]  err_code_r;
  logic        err_valid_r;

  // Classify the error being reported on entry to DONE.
  always_comb begin
    log_now_s = pready_nxt_s & pslverr_nxt_s;
    if (state_r == ST_IDLE) begin
      err_code_s = ERR_CODE_UNMAPPED;
    end else if (sl_ready_s) begin
      err_code_s = ERR_CODE_SLVERR;
    end else begin
      err_code_s = ERR_CODE_TIMEOUT;
    end
  end

  // Capture only the first error; a clear wins over a same-cycle error.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      err_addr_r  <= 32'h0000_0000;
      err_code_r  <= ERR_CODE_NONE;
      err_valid_r <= 1'b0;
    end else if (ERR_CLR) begin
      err_valid_r <= 1'b0;
    end else if (log_now_s && !err_valid_r) begin
      err_valid_r <= 1'b1;
      err_addr_r  <= paddr_nxt_s;
      err_code_r  <= err_code_s;
    end
  end

  assign ERR_ADDR  = err_addr_r;
  assign ERR_CODE  = err_code_r;
  assign ERR_VALID = err_valid_r;
`endif

endmodule
